// File: rtl/sha256_pkg.sv
// Shared constants and state type for the SHA-256 message padder.
// Byte 0 of a block is the most significant byte of the 512-bit bus.
package sha256_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int LEN_OFFSET = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ACCUM,
    PAD,
    EMIT,
    EMIT_LAST,
    LEN_BLK
  } pad_state_e;

  // Byte idx (LEN_OFFSET..63) of the big-endian 64-bit length field.
  function automatic logic [7:0] len_byte(input logic [63:0] len, input int idx);
    return len[8*(BLOCK_BYTES-1-idx) +: 8];
  endfunction

endpackage

// File: rtl/sha256_padder.sv
// Byte-serial SHA-256 padder: collects message bytes into 64-byte blocks,
// appends 0x80, zero fill and the 64-bit bit length, and hands blocks out.
//
// state     | meaning
// ACCUM     | accept message bytes / end_of_file (ready=1)
// PAD       | one cycle: write 0x80, zero fill, length if it fits
// EMIT      | offer a non-final block, wait for block_ready
// EMIT_LAST | offer the final block, wait for block_ready
// LEN_BLK   | build the extra block holding only padding and length
module sha256_padder
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   data_in,
  input  logic         data_valid,
  input  logic         end_of_file,
  output logic         ready,
  output logic [511:0] block_out,
  output logic         block_valid,
  output logic         block_last,
  input  logic         block_ready
);

  pad_state_e  state_q, state_d;
  logic [6:0]  cnt_q;
  logic [63:0] len_q;
  logic [7:0]  buf_q [BLOCK_BYTES];
  logic        defer_pad_q;
  logic        len_pending_q;
  logic        xfer;

  assign ready       = (state_q == ACCUM) && !rst;
  assign block_valid = (state_q == EMIT) || (state_q == EMIT_LAST);
  assign block_last  = (state_q == EMIT_LAST);
  assign xfer        = block_valid && block_ready;

  always_comb begin
    block_out = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      block_out[8*(BLOCK_BYTES-1-i) +: 8] = buf_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: begin
        if (end_of_file)
          state_d = PAD;
        else if (data_valid && cnt_q == 7'(BLOCK_BYTES-1))
          state_d = EMIT;
      end
      PAD: begin
        if (cnt_q <= 7'(LEN_OFFSET-1)) state_d = EMIT_LAST;
        else                           state_d = EMIT;
      end
      EMIT: begin
        if (xfer) state_d = len_pending_q ? LEN_BLK : ACCUM;
      end
      LEN_BLK:   state_d = EMIT_LAST;
      EMIT_LAST: begin
        if (xfer) state_d = ACCUM;
      end
      default:   state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      len_q         <= '0;
      defer_pad_q   <= 1'b0;
      len_pending_q <= 1'b0;
      for (int i = 0; i < BLOCK_BYTES; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (data_valid) begin
            buf_q[cnt_q[5:0]] <= data_in;
            cnt_q             <= cnt_q + 7'd1;
            len_q             <= len_q + 64'd8;
          end
        end
        PAD: begin
          // A message ending exactly on a block boundary goes out untouched;
          // its 0x80 moves to the front of the length block.
          if (cnt_q == 7'(BLOCK_BYTES)) begin
            defer_pad_q   <= 1'b1;
            len_pending_q <= 1'b1;
          end else begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
              if (7'(i) == cnt_q)
                buf_q[i] <= PAD_BYTE;
              else if (7'(i) > cnt_q)
                buf_q[i] <= (cnt_q <= 7'(LEN_OFFSET-1) && i >= LEN_OFFSET)
                            ? len_byte(len_q, i) : 8'h00;
            end
            if (cnt_q > 7'(LEN_OFFSET-1)) len_pending_q <= 1'b1;
          end
        end
        EMIT: begin
          if (xfer) cnt_q <= '0;
        end
        LEN_BLK: begin
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (i >= LEN_OFFSET)
              buf_q[i] <= len_byte(len_q, i);
            else if (i == 0 && defer_pad_q)
              buf_q[i] <= PAD_BYTE;
            else
              buf_q[i] <= 8'h00;
          end
          defer_pad_q   <= 1'b0;
          len_pending_q <= 1'b0;
        end
        EMIT_LAST: begin
          if (xfer) begin
            cnt_q         <= '0;
            len_q         <= '0;
            defer_pad_q   <= 1'b0;
            len_pending_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
